// File: rtl/cgra_power_sequencer.sv
// cgra_power_sequencer: CGRA power-down/up sequencing (drain, isolate, gate, switch, reset release).
// Optional macro CGRA_PWR_TIMEOUT_EN adds a switch-ack timeout with a sticky error flag.
module cgra_power_sequencer #(
  parameter int ISO_CYC     = 4,
  parameter int RST_CYC     = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwr_off_req_i,
  input  logic       retain_i,
  input  logic       cgra_busy_i,
  input  logic       switch_ack_ni,
  output logic       clk_en_o,
  output logic       switch_no,
  output logic       iso_no,
  output logic       logic_rst_no,
  output logic       ram_retentive_no,
  output logic [2:0] state_o,
  output logic       done_o,
  output logic       timeout_err_o
);
  typedef enum logic [2:0] {
    RST_REL = 3'd0,
    ON      = 3'd1,
    DRAIN   = 3'd2,
    ISO     = 3'd3,
    GATE    = 3'd4,
    PWR_OFF = 3'd5,
    OFF     = 3'd6,
    PWR_ON  = 3'd7
  } state_t;
  localparam int ISO_E = (ISO_CYC < 1) ? 1 : ISO_CYC;
  localparam int RST_E = (RST_CYC < 1) ? 1 : RST_CYC;
  localparam int CW    = $clog2(((ISO_E > RST_E) ? ISO_E : RST_E) + 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_retain, r_clk_en, r_switch_n, r_iso_n, r_lrst_n, r_ram_n, r_done;
  logic          w_to;
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      RST_REL: if (r_cnt <= CW'(1)) w_next = ON; else w_cnt = r_cnt - CW'(1);
      ON:      if (pwr_off_req_i) w_next = DRAIN;
      DRAIN: begin
        if (!pwr_off_req_i) w_next = ON;
        else if (!cgra_busy_i) begin
          w_next = ISO;
          w_cnt  = CW'(ISO_E);
        end
      end
      ISO:     if (r_cnt <= CW'(1)) w_next = GATE; else w_cnt = r_cnt - CW'(1);
      GATE:    w_next = PWR_OFF;
      PWR_OFF: if (switch_ack_ni || w_to) w_next = OFF;
      OFF:     if (!pwr_off_req_i) w_next = PWR_ON;
      PWR_ON: begin
        if (!switch_ack_ni || w_to) begin
          w_next = RST_REL;
          w_cnt  = CW'(RST_E);
        end
      end
      default: w_next = RST_REL;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RST_REL;
      r_cnt      <= CW'(RST_E);
      r_retain   <= 1'b0;
      r_clk_en   <= 1'b1;
      r_switch_n <= 1'b0;
      r_iso_n    <= 1'b0;
      r_lrst_n   <= 1'b0;
      r_ram_n    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_done  <= (r_state == PWR_OFF && w_next == OFF) || (r_state == RST_REL && w_next == ON);
      // Outputs are updated on the edge that enters a state, so they settle with state_o.
      if (w_next != r_state) begin
        case (w_next)
          ISO: begin
            r_iso_n  <= 1'b0;
            r_retain <= retain_i;
          end
          GATE: begin
            r_clk_en <= 1'b0;
            r_lrst_n <= 1'b0;
            r_ram_n  <= ~r_retain;
          end
          PWR_OFF: r_switch_n <= 1'b1;
          PWR_ON:  r_switch_n <= 1'b0;
          RST_REL: begin
            r_clk_en <= 1'b1;
            r_ram_n  <= 1'b1;
          end
          ON: begin
            if (r_state == RST_REL) begin
              r_iso_n  <= 1'b1;
              r_lrst_n <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
`ifdef CGRA_PWR_TIMEOUT_EN
  localparam int TO_E = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
  localparam int TW   = $clog2(TO_E + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;
  logic          w_wait;
  assign w_wait = (r_state == PWR_OFF) || (r_state == PWR_ON);
  assign w_to   = w_wait && (r_tcnt == TW'(TO_E - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= (!w_wait || w_next != r_state) ? '0 : r_tcnt + TW'(1);
      if (r_state == ON && w_next == DRAIN) r_err <= 1'b0;
      else if (w_to && w_next != r_state) r_err <= 1'b1;
    end
  end
  assign timeout_err_o = r_err;
`else
  assign w_to          = 1'b0;
  assign timeout_err_o = 1'b0;
`endif
  assign state_o          = r_state;
  assign clk_en_o         = r_clk_en;
  assign switch_no        = r_switch_n;
  assign iso_no           = r_iso_n;
  assign logic_rst_no     = r_lrst_n;
  assign ram_retentive_no = r_ram_n;
  assign done_o           = r_done;
endmodule

// File: tb/tb_cgra_power_sequencer.sv
// tb_cgra_power_sequencer: directed checks of boot, power-down/up, aborts and async reset.
module tb_cgra_power_sequencer;
  logic       clk_i = 1'b0;
  logic       rst_ni, pwr_off_req_i, retain_i, cgra_busy_i, switch_ack_ni;
  logic       clk_en_o, switch_no, iso_no, logic_rst_no, ram_retentive_no, done_o, timeout_err_o;
  logic [2:0] state_o;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_done   = 0;
  int         done_base;
  cgra_power_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pwr_off_req_i(pwr_off_req_i), .retain_i(retain_i),
    .cgra_busy_i(cgra_busy_i), .switch_ack_ni(switch_ack_ni), .clk_en_o(clk_en_o),
    .switch_no(switch_no), .iso_no(iso_no), .logic_rst_no(logic_rst_no),
    .ram_retentive_no(ram_retentive_no), .state_o(state_o), .done_o(done_o),
    .timeout_err_o(timeout_err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (done_o === 1'b1) n_done++;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_clk_en"}, 32'(clk_en_o), 1);
    chk({tag, "_switch"}, 32'(switch_no), 0);
    chk({tag, "_iso"}, 32'(iso_no), 0);
    chk({tag, "_lrst"}, 32'(logic_rst_no), 0);
    chk({tag, "_ram"}, 32'(ram_retentive_no), 1);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(timeout_err_o), 0);
  endtask
  initial begin
    rst_ni = 1'b0; pwr_off_req_i = 1'b0; retain_i = 1'b0; cgra_busy_i = 1'b0; switch_ack_ni = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    // Cold boot: eight cycles of reset release, then ON with a done pulse.
    rst_ni = 1'b1;
    tick(7);
    chk("boot_rel_state", 32'(state_o), 0);
    chk("boot_rel_lrst", 32'(logic_rst_no), 0);
    tick();
    chk("boot_on_state", 32'(state_o), 1);
    chk("boot_on_iso", 32'(iso_no), 1);
    chk("boot_on_lrst", 32'(logic_rst_no), 1);
    chk("boot_on_done", 32'(done_o), 1);
    tick();
    chk("boot_done_clr", 32'(done_o), 0);
    // Retentive power-down with the CGRA busy for five cycles.
    pwr_off_req_i = 1'b1; retain_i = 1'b1; cgra_busy_i = 1'b1;
    tick();
    chk("pd_drain", 32'(state_o), 2);
    tick(4);
    chk("pd_drain_busy", 32'(state_o), 2);
    chk("pd_drain_iso", 32'(iso_no), 1);
    cgra_busy_i = 1'b0;
    tick();
    chk("pd_iso_state", 32'(state_o), 3);
    chk("pd_iso_iso", 32'(iso_no), 0);
    retain_i = 1'b0;
    tick(3);
    chk("pd_iso_hold", 32'(state_o), 3);
    chk("pd_iso_clk", 32'(clk_en_o), 1);
    tick();
    chk("pd_gate_state", 32'(state_o), 4);
    chk("pd_gate_clk", 32'(clk_en_o), 0);
    chk("pd_gate_lrst", 32'(logic_rst_no), 0);
    chk("pd_gate_ram", 32'(ram_retentive_no), 0);
    tick();
    chk("pd_pwroff_state", 32'(state_o), 5);
    chk("pd_pwroff_sw", 32'(switch_no), 1);
    tick(3);
    chk("pd_wait_ack", 32'(state_o), 5);
    switch_ack_ni = 1'b1;
    tick();
    chk("pd_off_state", 32'(state_o), 6);
    chk("pd_off_done", 32'(done_o), 1);
    tick();
    chk("pd_off_done_clr", 32'(done_o), 0);
    chk("pd_off_hold", 32'(state_o), 6);
    // Power back up.
    pwr_off_req_i = 1'b0;
    tick();
    chk("pu_pwron_state", 32'(state_o), 7);
    chk("pu_pwron_sw", 32'(switch_no), 0);
    tick();
    chk("pu_wait_ack", 32'(state_o), 7);
    switch_ack_ni = 1'b0;
    tick();
    chk("pu_rel_state", 32'(state_o), 0);
    chk("pu_rel_clk", 32'(clk_en_o), 1);
    chk("pu_rel_ram", 32'(ram_retentive_no), 1);
    chk("pu_rel_iso", 32'(iso_no), 0);
    tick(7);
    chk("pu_rel_hold", 32'(state_o), 0);
    tick();
    chk("pu_on_state", 32'(state_o), 1);
    chk("pu_on_done", 32'(done_o), 1);
    chk("pu_on_iso", 32'(iso_no), 1);
    tick();
    // Request withdrawn while draining: straight back to ON, no output activity.
    done_base = n_done;
    pwr_off_req_i = 1'b1; cgra_busy_i = 1'b1;
    tick();
    chk("ab_drain", 32'(state_o), 2);
    tick();
    chk("ab_drain_iso", 32'(iso_no), 1);
    pwr_off_req_i = 1'b0;
    tick();
    chk("ab_on_state", 32'(state_o), 1);
    chk("ab_on_iso", 32'(iso_no), 1);
    chk("ab_on_clk", 32'(clk_en_o), 1);
    tick();
    chk("ab_no_done", 32'(n_done - done_base), 0);
    // Request withdrawn in ISO: non-retentive sequence completes, then powers up.
    cgra_busy_i = 1'b0; retain_i = 1'b0; done_base = n_done;
    pwr_off_req_i = 1'b1;
    tick(2);
    chk("iso_ab_iso", 32'(state_o), 3);
    pwr_off_req_i = 1'b0;
    tick(3);
    chk("iso_ab_hold", 32'(state_o), 3);
    tick();
    chk("iso_ab_gate", 32'(state_o), 4);
    chk("iso_ab_ram", 32'(ram_retentive_no), 1);
    tick();
    chk("iso_ab_pwroff", 32'(state_o), 5);
    switch_ack_ni = 1'b1;
    tick();
    chk("iso_ab_off", 32'(state_o), 6);
    tick();
    chk("iso_ab_pwron", 32'(state_o), 7);
    switch_ack_ni = 1'b0;
    tick();
    chk("iso_ab_rel", 32'(state_o), 0);
    tick(7);
    chk("iso_ab_rel_hold", 32'(state_o), 0);
    tick();
    chk("iso_ab_on", 32'(state_o), 1);
    tick();
    chk("iso_ab_dones", 32'(n_done - done_base), 2);
`ifdef CGRA_PWR_TIMEOUT_EN
    // Ack never arrives: advance after the timeout and flag the error until the next drain.
    pwr_off_req_i = 1'b1;
    tick(7);
    chk("to_pwroff", 32'(state_o), 5);
    tick(1023);
    chk("to_wait", 32'(state_o), 5);
    tick();
    chk("to_off", 32'(state_o), 6);
    chk("to_err", 32'(timeout_err_o), 1);
    pwr_off_req_i = 1'b0;
    tick(2);
    chk("to_rel", 32'(state_o), 0);
    chk("to_err_sticky", 32'(timeout_err_o), 1);
    tick(8);
    chk("to_on", 32'(state_o), 1);
    pwr_off_req_i = 1'b1; cgra_busy_i = 1'b1;
    tick();
    chk("to_err_clr", 32'(timeout_err_o), 0);
    pwr_off_req_i = 1'b0; cgra_busy_i = 1'b0;
    tick();
`else
    chk("no_to_err", 32'(timeout_err_o), 0);
`endif
    // Asynchronous reset while waiting in PWR_OFF.
    pwr_off_req_i = 1'b1;
    tick(7);
    chk("ar_pwroff", 32'(state_o), 5);
    chk("ar_pwroff_sw", 32'(switch_no), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_vals("ar");
    pwr_off_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick(7);
    chk("ar_rel_hold", 32'(state_o), 0);
    tick();
    chk("ar_on", 32'(state_o), 1);
    chk("ar_on_done", 32'(done_o), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cgra_power_sequencer.md
CGRA_POWER_SEQUENCER -- requirements
Module: cgra_power_sequencer

Interface
REQ-001 SHALL have parameter ISO_CYC, default 4: cycles isolation is held before the clock is gated (value 0 treated as 1).
REQ-002 SHALL have parameter RST_CYC, default 8: cycles logic reset is held after the clock is re-enabled (value 0 treated as 1).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024: cycles to wait for the switch ack before timeout (used only with the macro in REQ-021).
REQ-004 SHALL have port clk_i, input, 1: single clock.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pwr_off_req_i, input, 1: level request; 1 = power the CGRA down, 0 = keep or bring it up.
REQ-007 SHALL have port retain_i, input, 1: 1 = keep the context memory retentive while off.
REQ-008 SHALL have port cgra_busy_i, input, 1: CGRA has an outstanding kernel or bus transaction.
REQ-009 SHALL have port switch_ack_ni, input, 1: power-switch ack; 0 = on, 1 = off.
REQ-010 SHALL have output ports clk_en_o (1: clock on enable), switch_no (1: switch, 0 = power on), iso_no (1: 0 = isolated), logic_rst_no (1: 0 = reset held) and ram_retentive_no (1: 0 = retentive).
REQ-011 SHALL have outputs state_o (3: FSM state encoding), done_o (1: one-cycle pulse when a sequence completes) and timeout_err_o (1: sticky error).

Function
REQ-012 FSM states and state_o encodings: RST_REL=0, ON=1, DRAIN=2, ISO=3, GATE=4, PWR_OFF=5, OFF=6, PWR_ON=7.
REQ-013 ON with pwr_off_req_i=1 -> DRAIN; in DRAIN, go to ISO on the first cycle with cgra_busy_i=0.
   - If pwr_off_req_i falls while in DRAIN -> return to ON; no output changes.
REQ-014 DRAIN->ISO transition:
   - drive iso_no=0;
   - sample retain_i into an internal flag;
   - load the counter; stay ISO_CYC cycles, then -> GATE.
REQ-015 GATE lasts one cycle: clk_en_o=0, logic_rst_no=0, ram_retentive_no=~retain flag; then -> PWR_OFF.
REQ-016 PWR_OFF: switch_no=1; wait for switch_ack_ni=1, then -> OFF and pulse done_o.
REQ-017 OFF with pwr_off_req_i=0 -> PWR_ON.
   - PWR_ON: switch_no=0; wait for switch_ack_ni=0, then -> RST_REL with clk_en_o=1 and ram_retentive_no=1.
REQ-018 RST_REL holds logic_rst_no=0 and iso_no=0 for RST_CYC cycles, then -> ON.
   - On entering ON: iso_no=1, logic_rst_no=1, done_o pulses.
REQ-019 Once in ISO or later, a request drop does not abort the sequence: it completes to OFF, then powers up at once.
REQ-020 All outputs are registered; each output change appears the cycle after the triggering transition.

Configuration
REQ-021 With macro CGRA_PWR_TIMEOUT_EN defined:
   - a counter runs in PWR_OFF/PWR_ON; after ACK_TIMEOUT cycles without the ack, set timeout_err_o=1 and advance as if acked;
   - timeout_err_o clears on entry to DRAIN.
   Without the macro: wait for the ack indefinitely; timeout_err_o tied 0; no counter logic.

Reset
REQ-022 While rst_ni=0: state=RST_REL, counter=RST_CYC, clk_en_o=1, switch_no=0, iso_no=0, logic_rst_no=0, ram_retentive_no=1, done_o=0, timeout_err_o=0, retain flag=0.
REQ-023 After reset release: RST_REL runs RST_CYC cycles, then ON with done_o pulse; a reset mid-sequence returns to this state from any state.

Verification
REQ-024 Cold boot: release rst_ni -> after 8 cycles state_o=1, iso_no=1, logic_rst_no=1, one done_o pulse.
REQ-025 Power-down with cgra_busy_i=1 for 5 cycles, retain_i=1 -> iso_no falls after busy drops, clk_en_o=0 four cycles later, ram_retentive_no=0, switch_no=1, ack high -> state_o=6 and done_o.
REQ-026 Request drops in DRAIN -> state_o back to 1; iso_no and clk_en_o never toggle.
REQ-027 Request drops in ISO -> sequence reaches OFF, then PWR_ON, RST_REL for 8 cycles, ON; two done_o pulses.
REQ-028 With CGRA_PWR_TIMEOUT_EN and switch_ack_ni held 0 in PWR_OFF -> after 1024 cycles timeout_err_o=1, state_o=6; the error clears on the next DRAIN.
REQ-029 rst_ni asserted in PWR_OFF -> outputs take the REQ-022 values immediately, without waiting for a clock.
